// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types and parameter defaults for btn_debounce
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ARM_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        ARM_RELEASE = 2'd3
    } btn_state_t;

    // 10 ms and 500 ms at a 100 MHz sclk
    localparam int DEBOUNCE_CYCLES_DEF   = 1_000_000;
    localparam int LONG_PRESS_CYCLES_DEF = 50_000_000;

endpackage

// File: rtl/btn_debounce_if.sv
// rtl/btn_debounce_if.sv - raw button inputs and conditioned outputs (btn_long with BTN_LONG_PRESS_EN)
interface btn_debounce_if #(
    parameter int NUM_BTN = 4
);
    logic [NUM_BTN-1:0] btn;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
`ifdef BTN_LONG_PRESS_EN
    logic [NUM_BTN-1:0] btn_long;

    modport master (output btn, input btn_level, input btn_press, input btn_release, input btn_long);
    modport slave  (input btn, output btn_level, output btn_press, output btn_release, output btn_long);
`else
    modport master (output btn, input btn_level, input btn_press, input btn_release);
    modport slave  (input btn, output btn_level, output btn_press, output btn_release);
`endif
endinterface

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one button: 2-flop synchroniser, debounce FSM, optional hold counter
// Hold counter and long_o exist only when BTN_LONG_PRESS_EN is defined.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef BTN_LONG_PRESS_EN
    ,
    parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF
`endif
) (
    input  logic sclk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
`ifdef BTN_LONG_PRESS_EN
    ,
    output logic long_o
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // The arming sample already counts as one, so the change is accepted
    // on the sample that would bring the count to DEBOUNCE_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_q, s2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

`ifdef BTN_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;
`endif

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef BTN_LONG_PRESS_EN
            hold_q    <= '0;
            long_q    <= 1'b0;
`endif
        end else begin
            s1_q      <= btn_i;
            s2_q      <= s1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
`ifdef BTN_LONG_PRESS_EN
            hold_q    <= hold_d;
            long_q    <= long_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:        if (s2_q) state_d = ARM_PRESS;
            ARM_PRESS:   if (!s2_q) state_d = IDLE;
                         else if (cnt_q == CNT_LAST) state_d = PRESSED;
            PRESSED:     if (!s2_q) state_d = ARM_RELEASE;
            ARM_RELEASE: if (s2_q) state_d = PRESSED;
                         else if (cnt_q == CNT_LAST) state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (state_d != state_q) begin
            cnt_d = (state_d == ARM_PRESS || state_d == ARM_RELEASE) ? CNT_ONE : '0;
        end else if (state_q == ARM_PRESS || state_q == ARM_RELEASE) begin
            cnt_d = cnt_q + CNT_ONE;
        end
        if (state_q == ARM_PRESS && state_d == PRESSED) begin
            level_d = 1'b1;
            press_d = 1'b1;
        end
        if (state_q == ARM_RELEASE && state_d == IDLE) begin
            level_d   = 1'b0;
            release_d = 1'b1;
        end
`ifdef BTN_LONG_PRESS_EN
        hold_d = hold_q;
        if (state_q == IDLE || (state_q == ARM_PRESS && state_d == PRESSED)) begin
            hold_d = '0;
        end else if ((state_q == PRESSED || state_q == ARM_RELEASE) && hold_q != HOLD_MAX) begin
            hold_d = hold_q + HOLD_W'(1);
        end
        // Saturation at HOLD_MAX is what keeps this from repeating
        long_d = (hold_d == HOLD_MAX) && (hold_q != HOLD_MAX);
`endif
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
`ifdef BTN_LONG_PRESS_EN
    assign long_o    = long_q;
`endif

endmodule

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - NUM_BTN independent debounce channels; BTN_LONG_PRESS_EN adds btn_long
module btn_debounce
    import btn_pkg::*;
#(
    parameter int NUM_BTN           = 4,
    parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF
) (
    input  logic           sclk,
    input  logic           rst_n,
    btn_debounce_if.slave  bus
);

    // Empty marker block: its presence in the hierarchy flags an illegal configuration
    if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 1) begin : g_param_range_illegal
    end

    logic [NUM_BTN-1:0] level_w;
    logic [NUM_BTN-1:0] press_w;
    logic [NUM_BTN-1:0] release_w;
`ifdef BTN_LONG_PRESS_EN
    logic [NUM_BTN-1:0] long_w;
`endif

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES)
`ifdef BTN_LONG_PRESS_EN
            ,
            .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
`endif
        ) u_ch (
            .sclk      (sclk),
            .rst_n     (rst_n),
            .btn_i     (bus.btn[i]),
            .level_o   (level_w[i]),
            .press_o   (press_w[i]),
            .release_o (release_w[i])
`ifdef BTN_LONG_PRESS_EN
            ,
            .long_o    (long_w[i])
`endif
        );
    end

    assign bus.btn_level   = level_w;
    assign bus.btn_press   = press_w;
    assign bus.btn_release = release_w;
`ifdef BTN_LONG_PRESS_EN
    assign bus.btn_long    = long_w;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - directed bench for btn_debounce (DEBOUNCE_CYCLES=4, long-press part under BTN_LONG_PRESS_EN)
module tb_btn_debounce;

    logic sclk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    int   n_fail;

    btn_debounce_if #(.NUM_BTN(4)) bus ();

    btn_debounce #(
        .NUM_BTN           (4),
        .DEBOUNCE_CYCLES   (4),
        .LONG_PRESS_CYCLES (10)
    ) dut (
        .sclk  (sclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic run_expect(input string tag, input int n, input logic [3:0] lv,
                              input logic [3:0] pr, input logic [3:0] rl);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, "/level"}, bus.btn_level, lv);
            chk({tag, "/press"}, bus.btn_press, pr);
            chk({tag, "/release"}, bus.btn_release, rl);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.btn = 4'b0000;
        run_expect("reset", 2, 4'b0000, 4'b0000, 4'b0000);
        rst_n = 1'b1;
        run_expect("idle", 3, 4'b0000, 4'b0000, 4'b0000);

        // Clean press on btn[0]: first sample at the next edge, press 5 edges later
        bus.btn = 4'b0001;
        run_expect("clean_wait", 5, 4'b0000, 4'b0000, 4'b0000);
        run_expect("clean_press", 1, 4'b0001, 4'b0001, 4'b0000);
        run_expect("clean_hold", 1, 4'b0001, 4'b0000, 4'b0000);

        // Release of btn[0]
        bus.btn = 4'b0000;
        run_expect("rel_wait", 5, 4'b0001, 4'b0000, 4'b0000);
        run_expect("rel_pulse", 1, 4'b0000, 4'b0000, 4'b0001);
        run_expect("rel_after", 2, 4'b0000, 4'b0000, 4'b0000);

        // 23 ns glitch: two samples high, never accepted
        bus.btn = 4'b0001;
        #23;
        bus.btn = 4'b0000;
        run_expect("glitch", 12, 4'b0000, 4'b0000, 4'b0000);

        // Bounce 1,0,1,0 every 2 cycles, then hold
        for (int k = 0; k < 4; k++) begin
            bus.btn = (k % 2 == 0) ? 4'b0001 : 4'b0000;
            run_expect("bounce", 2, 4'b0000, 4'b0000, 4'b0000);
        end
        bus.btn = 4'b0001;
        run_expect("bounce_wait", 5, 4'b0000, 4'b0000, 4'b0000);
        run_expect("bounce_press", 1, 4'b0001, 4'b0001, 4'b0000);
        run_expect("bounce_hold", 2, 4'b0001, 4'b0000, 4'b0000);
        bus.btn = 4'b0000;
        run_expect("bounce_rwait", 5, 4'b0001, 4'b0000, 4'b0000);
        run_expect("bounce_rel", 1, 4'b0000, 4'b0000, 4'b0001);
        run_expect("bounce_idle", 2, 4'b0000, 4'b0000, 4'b0000);

        // Simultaneous press on buttons 0, 1 and 3
        bus.btn = 4'b1011;
        run_expect("sim_wait", 5, 4'b0000, 4'b0000, 4'b0000);
        run_expect("sim_press", 1, 4'b1011, 4'b1011, 4'b0000);
        bus.btn = 4'b0000;
        run_expect("sim_rwait", 5, 4'b1011, 4'b0000, 4'b0000);
        run_expect("sim_rel", 1, 4'b0000, 4'b0000, 4'b1011);
        run_expect("sim_idle", 2, 4'b0000, 4'b0000, 4'b0000);

        // Reset while btn[1] is arming
        bus.btn = 4'b0010;
        run_expect("arm", 4, 4'b0000, 4'b0000, 4'b0000);
        rst_n = 1'b0;
        run_expect("mid_reset", 3, 4'b0000, 4'b0000, 4'b0000);
        rst_n = 1'b1;
        run_expect("post_rst_wait", 5, 4'b0000, 4'b0000, 4'b0000);
        run_expect("post_rst_press", 1, 4'b0010, 4'b0010, 4'b0000);

        // Reset while pressed: level drops with no release pulse, fresh press follows
        rst_n = 1'b0;
        run_expect("pressed_reset", 1, 4'b0000, 4'b0000, 4'b0000);
        rst_n = 1'b1;
        run_expect("repress_wait", 5, 4'b0000, 4'b0000, 4'b0000);
        run_expect("repress", 1, 4'b0010, 4'b0010, 4'b0000);
        bus.btn = 4'b0000;
        run_expect("repress_rwait", 5, 4'b0010, 4'b0000, 4'b0000);
        run_expect("repress_rel", 1, 4'b0000, 4'b0000, 4'b0010);
        run_expect("final_idle", 2, 4'b0000, 4'b0000, 4'b0000);

`ifdef BTN_LONG_PRESS_EN
        // Long press on btn[3]: one pulse 10 cycles after the press pulse
        bus.btn = 4'b1000;
        run_expect("long_wait", 5, 4'b0000, 4'b0000, 4'b0000);
        run_expect("long_press", 1, 4'b1000, 4'b1000, 4'b0000);
        for (int k = 1; k <= 30; k++) begin
            tick();
            chk("long_pulse", bus.btn_long, (k == 10) ? 4'b1000 : 4'b0000);
            chk("long_level", bus.btn_level, 4'b1000);
        end
        bus.btn = 4'b0000;
        run_expect("long_rwait", 5, 4'b1000, 4'b0000, 4'b0000);
        run_expect("long_rel", 1, 4'b0000, 4'b0000, 4'b1000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
